// File: rtl/output_error_collector.sv
// output_error_collector: masks, clips and streams one batch of output-layer errors
module output_error_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_OUTPUT = 4,
  parameter int ADDR_WIDTH = 2,
  parameter bit CLIP_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [ADDR_WIDTH-1:0] i_action,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [ADDR_WIDTH-1:0] o_index,
  output logic                  o_last,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_overflow
);
  typedef enum logic {COLLECT, STREAM} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_OUTPUT - 1);
  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_wcnt, r_rptr, r_act, w_act, w_rnext;
  logic [DATA_WIDTH-1:0] r_buf [NUM_OUTPUT];
  logic [DATA_WIDTH-1:0] r_data, w_wdata;
  logic                  r_valid, r_last, r_overflow;
  logic                  w_nan, w_clip, w_wr, w_last_wr, w_hs;
  // Write-value selection (mask, then clip, NaN untouched) and next state
  always_comb begin
    w_act       = (r_wcnt == '0) ? i_action : r_act;
    w_nan       = (i_data[30:23] == 8'hFF) && (i_data[22:0] != '0);
    w_clip      = CLIP_EN && (i_data[30:23] >= 8'd127) && !w_nan;
    w_wdata     = (r_wcnt != w_act) ? '0 : w_clip ? {i_data[31], 31'h3F800000} : i_data;
    w_wr        = (r_state == COLLECT) && i_valid;
    w_last_wr   = w_wr && (r_wcnt == LAST);
    w_hs        = r_valid && i_ready;
    w_rnext     = (r_rptr == LAST) ? '0 : r_rptr + 1'b1;
    w_state_nxt = r_state;
    if (w_last_wr) w_state_nxt = STREAM;
    else if (w_hs && r_last) w_state_nxt = COLLECT;
  end
  // State register
  always_ff @(posedge clk) r_state <= rst_n ? COLLECT : w_state_nxt;
  // Counters, registered stream outputs and sticky overflow
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_wcnt     <= '0;
      r_rptr     <= '0;
      r_act      <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wcnt <= (r_wcnt == LAST) ? '0 : r_wcnt + 1'b1;
        if (r_wcnt == '0) r_act <= i_action;
      end
      if (w_last_wr) begin
        r_valid <= 1'b1;
        r_rptr  <= '0;
        r_data  <= r_buf[0];
        r_last  <= 1'b0;
      end
      if (w_hs) begin
        r_rptr  <= w_rnext;
        r_data  <= r_buf[w_rnext];
        r_last  <= (w_rnext == LAST);
        r_valid <= !r_last;
      end
      if (r_state == STREAM && i_valid) r_overflow <= 1'b1;
    end
  end
  // Error buffer; contents are don't-care after reset
  always_ff @(posedge clk) if (w_wr) r_buf[r_wcnt] <= w_wdata;
  assign o_data     = r_data;
  assign o_index    = r_rptr;
  assign o_last     = r_last;
  assign o_valid    = r_valid;
  assign o_overflow = r_overflow;
endmodule

// File: tb/tb_output_error_collector.sv
// tb_output_error_collector: directed checks of masking, clipping, streaming, overflow and reset
module tb_output_error_collector;
  logic        clk = 1'b0;
  logic        rst_n, i_valid, i_ready;
  logic [31:0] i_data;
  logic [1:0]  i_action;
  logic [31:0] o_data;
  logic [1:0]  o_index;
  logic        o_last, o_valid, o_overflow;
  int          n_checks = 0;
  int          n_fail = 0;

  output_error_collector dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data(i_data), .i_action(i_action),
    .o_data(o_data), .o_index(o_index), .o_last(o_last), .o_valid(o_valid),
    .i_ready(i_ready), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_last"}, 32'(o_last), 32'd0);
    chk({tag, "_index"}, 32'(o_index), 32'd0);
    chk({tag, "_data"}, o_data, 32'd0);
    chk({tag, "_ovf"}, 32'(o_overflow), 32'd0);
  endtask

  task automatic chk_elem(input string tag, input int k, input logic [31:0] e);
    chk($sformatf("%s_valid%0d", tag, k), 32'(o_valid), 32'd1);
    chk($sformatf("%s_index%0d", tag, k), 32'(o_index), 32'(k));
    chk($sformatf("%s_data%0d", tag, k), o_data, e);
    chk($sformatf("%s_last%0d", tag, k), 32'(o_last), 32'(k == 3));
  endtask

  task automatic run_batch(input logic [1:0] act, input int gap,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3);
    logic [31:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int k = 0; k < 4; k++) begin
      i_valid  = 1'b1;
      i_data   = d[k];
      i_action = (k == 0) ? act : act + 2'd1;
      tick();
      i_valid  = 1'b0;
      i_action = act + 2'd2;
      if (k == 2) chk("pre_valid", 32'(o_valid), 32'd0);
      if (k < 3) repeat (gap) tick();
    end
  endtask

  task automatic check_stream(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk_elem(tag, k, e[k]);
      tick();
    end
    chk({tag, "_done"}, 32'(o_valid), 32'd0);
    chk({tag, "_done_last"}, 32'(o_last), 32'd0);
  endtask

  initial begin
    rst_n = 1'b1; i_valid = 1'b0; i_data = '0; i_action = '0; i_ready = 1'b0;
    tick(); tick();
    chk_idle("reset");
    rst_n = 1'b0;
    tick();
    chk_idle("idle");

    // mask and clip
    i_ready = 1'b1;
    run_batch(2'd1, 0, 32'h3F000000, 32'hC0000000, 32'h40400000, 32'h3E800000);
    check_stream("mask", 32'h0, 32'hBF800000, 32'h0, 32'h0);

    // pass-through and special values
    run_batch(2'd2, 0, 32'h3F800000, 32'h40000000, 32'hBE800000, 32'hFF800000);
    check_stream("pass", 32'h0, 32'h0, 32'hBE800000, 32'h0);
    run_batch(2'd0, 0, 32'h7F800000, 32'h7FC00000, 32'h3F800000, 32'h0);
    check_stream("inf", 32'h3F800000, 32'h0, 32'h0, 32'h0);
    run_batch(2'd3, 0, 32'h0, 32'h0, 32'h0, 32'h7FC00000);
    check_stream("nan", 32'h0, 32'h0, 32'h0, 32'h7FC00000);
    run_batch(2'd1, 0, 32'h0, 32'hFF800000, 32'h0, 32'h0);
    check_stream("ninf", 32'h0, 32'hBF800000, 32'h0, 32'h0);
    run_batch(2'd2, 0, 32'h0, 32'h0, 32'h3F7FFFFF, 32'h0);
    check_stream("below1", 32'h0, 32'h0, 32'h3F7FFFFF, 32'h0);

    // backpressure
    i_ready = 1'b0;
    run_batch(2'd0, 0, 32'h3E000000, 32'h1, 32'h2, 32'h3);
    for (int s = 0; s < 3; s++) begin
      chk_elem("stall", 0, 32'h3E000000);
      tick();
    end
    i_ready = 1'b1;
    chk_elem("bp", 0, 32'h3E000000);
    tick();
    chk_elem("bp", 1, 32'h0);
    i_ready = 1'b0;
    tick();
    chk_elem("bp_hold", 1, 32'h0);
    i_ready = 1'b1;
    tick();
    chk_elem("bp", 2, 32'h0);
    tick();
    chk_elem("bp", 3, 32'h0);
    tick();
    chk("bp_done", 32'(o_valid), 32'd0);

    // gapped input, action sampled only with first word
    run_batch(2'd1, 2, 32'h3F000000, 32'hC0000000, 32'h40400000, 32'h3E800000);
    check_stream("gap", 32'h0, 32'hBF800000, 32'h0, 32'h0);
    chk("ovf_before", 32'(o_overflow), 32'd0);

    // overflow on second stream cycle
    run_batch(2'd1, 0, 32'h3F000000, 32'hC0000000, 32'h40400000, 32'h3E800000);
    chk_elem("ovf", 0, 32'h0);
    tick();
    i_valid = 1'b1; i_data = 32'h40400000;
    chk_elem("ovf", 1, 32'hBF800000);
    tick();
    i_valid = 1'b0;
    chk("ovf_set", 32'(o_overflow), 32'd1);
    chk_elem("ovf", 2, 32'h0);
    tick();
    chk_elem("ovf", 3, 32'h0);
    tick();
    chk("ovf_done", 32'(o_valid), 32'd0);
    run_batch(2'd0, 0, 32'h3E800000, 32'h1, 32'h2, 32'h3);
    check_stream("after_ovf", 32'h3E800000, 32'h0, 32'h0, 32'h0);
    chk("ovf_sticky", 32'(o_overflow), 32'd1);

    // reset after two collected words
    i_valid = 1'b1; i_action = 2'd0; i_data = 32'h3E800000;
    tick();
    i_action = 2'd3;
    tick();
    i_valid = 1'b0; rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    chk_idle("rst_collect");
    run_batch(2'd3, 0, 32'h1, 32'h2, 32'h3, 32'hBE800000);
    check_stream("post_rst1", 32'h0, 32'h0, 32'h0, 32'hBE800000);

    // reset mid-stream
    run_batch(2'd1, 0, 32'h3F000000, 32'hC0000000, 32'h40400000, 32'h3E800000);
    tick();
    chk_elem("pre_rst", 1, 32'hBF800000);
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    chk_idle("rst_stream");
    run_batch(2'd2, 0, 32'h3F000000, 32'hC0000000, 32'h40400000, 32'h3E800000);
    check_stream("post_rst2", 32'h0, 32'h0, 32'h3F800000, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/output_error_collector.md
Name: output_error_collector

Overview:
- Sits directly downstream of the output-layer error subtractor (node minus expected, 7-clock float adder). It receives one IEEE-754 single-precision error per output node.
- Collects one batch of NUM_OUTPUT errors per training sample. Errors for non-taken actions are masked to +0.0, as DQN requires. Optional gradient clipping to [-1.0, +1.0] is applied.
- Streams the finished error vector to the hidden-layer back-propagation stage through a valid/ready handshake.

Parameters:
- DATA_WIDTH, 32, float word width; only 32 is supported.
- NUM_OUTPUT, 4, number of output nodes (actions) per batch; must be at least 2.
- ADDR_WIDTH, 2, index width; ceil(log2(NUM_OUTPUT)).
- CLIP_EN, 1, when 1, clamps each error magnitude to at most 1.0.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-high reset (asserted when 1); the name is kept per the codebase convention.
- i_valid  in  1  one error word is present this cycle; no backpressure toward the upstream adder.
- i_data  in  DATA_WIDTH  error word (node - expected).
- i_action  in  ADDR_WIDTH  taken-action index; sampled only with the first error of a batch.
- o_data  out  DATA_WIDTH  masked and clipped error.
- o_index  out  ADDR_WIDTH  output-node index of o_data.
- o_last  out  1  high with the element whose index is NUM_OUTPUT-1.
- o_valid  out  1  output element valid.
- i_ready  in  1  downstream accepts the element; a handshake occurs when o_valid and i_ready are both 1.
- o_overflow  out  1  sticky flag: an error arrived while the block was streaming and was dropped.

Behaviour:
- Reset (rst_n=1 at an edge):
  - state goes to COLLECT; write count and read pointer go to 0.
  - o_valid, o_last, o_overflow, o_data and o_index all go to 0.
  - Buffer contents become don't-care.
  - Reset wins over every simultaneous event, including mid-batch and mid-stream; any partial batch is discarded.
- State COLLECT:
  - Each cycle with i_valid=1 writes buffer[wcnt] and increments wcnt.
  - When wcnt=0 and i_valid=1, i_action is latched as act_r.
  - The written value is taken from the first rule below that matches:
    - If wcnt != act_r, write 32'h00000000. For the first element, compare against the i_action value being latched.
    - If CLIP_EN=1, exponent field >= 127, and the word is not NaN (exp != 255 or mantissa = 0), write {sign, 31'h3F800000 & 31-bit mask}, i.e. ±1.0. Infinity clips to ±1.0.
    - NaN passes through unchanged.
    - Otherwise write i_data unchanged.
  - On the write with wcnt=NUM_OUTPUT-1: wcnt wraps to 0 and the state moves to STREAM next cycle.
- State STREAM:
  - o_valid=1 from the first cycle after the last write, so latency from last error accepted to first o_valid is 1 clock.
  - o_data=buffer[rptr], o_index=rptr, o_last=(rptr==NUM_OUTPUT-1).
  - Outputs are registered and held stable while o_valid=1 and i_ready=0.
  - Each handshake advances rptr; with continuous i_ready, one element per cycle is streamed, NUM_OUTPUT cycles in total.
  - The handshake on the o_last element: rptr goes to 0, o_valid goes to 0 and the state returns to COLLECT on the next edge.
  - i_valid=1 in any STREAM cycle, including the final handshake cycle, drops the word and sets o_overflow=1. o_overflow clears only on reset.
- Ordering and arithmetic:
  - Elements are emitted strictly in index order 0..NUM_OUTPUT-1.
  - No float arithmetic is performed; clipping is bit manipulation only.
  - ADDR_WIDTH counters never exceed NUM_OUTPUT-1; wrap uses an explicit compare, not a power-of-two overflow.
- Throughput: a batch occupies NUM_OUTPUT collect cycles plus at least NUM_OUTPUT stream cycles.

Test Plan:
- Masking + clip:
  - Stimulus: CLIP_EN=1, i_action=1 with the first word, i_data = 3F000000, C0000000, 40400000, 3E800000 on consecutive cycles; i_ready=1.
  - Required: o_valid is high 1 clock after the 4th input, then (index, data) = (0,00000000), (1,BF800000), (2,00000000), (3,00000000) on 4 consecutive cycles, with o_last only on index 3.
- Pass-through:
  - Stimulus: CLIP_EN=1, i_action=2, error at index 2 = BE800000 (-0.25).
  - Required: index 2 outputs BE800000 unchanged; 7F800000 (+inf) at the taken action outputs 3F800000; 7FC00000 (NaN) outputs 7FC00000.
- Backpressure:
  - Stimulus: i_ready held low for 3 cycles after o_valid rises, then toggled 1,0,1,1.
  - Required: o_data/o_index stay stable while stalled; every index 0..3 appears exactly once; o_valid drops after the index-3 handshake.
- Gapped input:
  - Stimulus: i_valid with idle gaps between the 4 errors.
  - Required: the same output vector as gap-free input; i_action is sampled only with the first word.
- Overflow:
  - Stimulus: i_valid=1 in the 2nd stream cycle.
  - Required: o_overflow=1 and stays 1; the streamed vector is unchanged; the next batch collects normally starting at index 0.
- Reset mid-operation:
  - Stimulus: assert rst_n after 2 collected words, and again mid-stream.
  - Required: on the following edge all outputs are 0; a fresh 4-word batch then produces a correct vector.
